// File: rtl/adsr_pkg.sv
// Shared encodings and saturating helpers for the ADSR envelope stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adsr_pkg;

    localparam int ENV_W = 10;

    localparam logic [ENV_W-1:0] ENV_MAX = 10'd1023;
    localparam logic [ENV_W-1:0] MID     = 10'd512;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Add a rate to the envelope, pinning at full scale instead of wrapping.
    function automatic logic [ENV_W-1:0] sat_add(input logic [ENV_W-1:0] a,
                                                 input logic [7:0]       b);
        logic [ENV_W:0] sum;
        sum = {1'b0, a} + {3'b000, b};
        return sum[ENV_W] ? ENV_MAX : sum[ENV_W-1:0];
    endfunction

    // Subtract a rate from the envelope, never going below floor_v.
    // The extra top bit is the borrow: set means the difference went negative.
    function automatic logic [ENV_W-1:0] sat_sub(input logic [ENV_W-1:0] a,
                                                 input logic [7:0]       b,
                                                 input logic [ENV_W-1:0] floor_v);
        logic [ENV_W:0] diff;
        diff = {1'b0, a} - {3'b000, b};
        if (diff[ENV_W] || (diff[ENV_W-1:0] < floor_v))
            return floor_v;
        return diff[ENV_W-1:0];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle envelope tick every TICK_DIV clocks.
// Latency: tick is combinational from the counter, high in the cycle where count == TICK_DIV-1.
// Backpressure: none; the counter never stalls and is only cleared by reset.
module tick_divider #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk_50MHz,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap on the tick cycle.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope keyed by gate, applied to an offset-binary sample stream.
// Latency: wave_out is registered, one clock after wave_in/env; env steps on divided ticks.
// Backpressure: none; a new sample is accepted and produced every clock.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    input  logic             gate,
    input  logic [ENV_W-1:0] wave_in,
    input  logic [7:0]       attack_rate,
    input  logic [7:0]       decay_rate,
    input  logic [ENV_W-1:0] sustain_level,
    input  logic [7:0]       release_rate,
    output logic [ENV_W-1:0] wave_out,
    output logic [ENV_W-1:0] env,
    output logic             busy
);

    logic                    tick;
    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [ENV_W-1:0]        env_nxt;
    logic signed [ENV_W:0]   s;
    logic signed [2*ENV_W:0] p;
    logic [ENV_W-1:0]        wave_nxt;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .tick      (tick)
    );

    // State register.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: a gate change always wins; completion moves on from the registered env.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (gate) state_nxt = ST_ATTACK;
            ST_ATTACK:  if (!gate)                     state_nxt = ST_RELEASE;
                        else if (env == ENV_MAX)       state_nxt = ST_DECAY;
            ST_DECAY:   if (!gate)                     state_nxt = ST_RELEASE;
                        else if (env == sustain_level) state_nxt = ST_SUSTAIN;
            ST_SUSTAIN: if (!gate)                     state_nxt = ST_RELEASE;
            ST_RELEASE: if (gate)                      state_nxt = ST_ATTACK;
                        else if (env == '0)            state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Envelope step. Steps are suppressed on cycles where the gate is about to
    // change the state, so the level carries over unchanged into RELEASE/ATTACK.
    // A zero rate means "go straight to the target".
    always_comb begin
        env_nxt = env;
        case (state)
            ST_IDLE:    env_nxt = '0;
            ST_ATTACK:  if (gate && tick)
                            env_nxt = (attack_rate == '0) ? ENV_MAX
                                                          : sat_add(env, attack_rate);
            ST_DECAY:   if (gate && tick)
                            env_nxt = (decay_rate == '0) ? sustain_level
                                                         : sat_sub(env, decay_rate, sustain_level);
            ST_SUSTAIN: if (gate)
                            env_nxt = sustain_level;
            ST_RELEASE: if (!gate && tick)
                            env_nxt = (release_rate == '0) ? '0
                                                           : sat_sub(env, release_rate, '0);
            default:    env_nxt = '0;
        endcase
    end

    // Envelope register.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n)
            env <= '0;
        else
            env <= env_nxt;
    end

    // Scale the signed sample by env/1024 with a floor shift, then re-centre.
    // The shifted product lies in -512..510, so the 10-bit re-centred sum
    // lands in 0..1022 and the modulo-1024 add never wraps.
    always_comb begin
        s        = $signed({1'b0, wave_in}) - 11'sd512;
        p        = (2*ENV_W+1)'(s) * (2*ENV_W+1)'($signed({1'b0, env}));
        wave_nxt = MID + ENV_W'(p >>> ENV_W);
    end

    // Output sample register.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n)
            wave_out <= MID;
        else
            wave_out <= wave_nxt;
    end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Downstream stage of the sine generator: consumes its 10-bit unsigned wave and applies an attack/decay/sustain/release amplitude envelope keyed by a gate.
- Produces a shaped 10-bit unsigned sample, mid-scale 512, for the output DAC/PWM stage.
- Envelope advances on a divided tick; sample scaling runs every clock.

Parameters:
- TICK_DIV, 50000: clk_50MHz cycles per envelope tick (1 kHz at 50 MHz); legal range 2..2^20.

Ports:
- clk_50MHz  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- gate  in  1  note on (1) / off (0), synchronous to clk_50MHz
- wave_in  in  10  unsigned offset-binary sample from sine generator
- attack_rate  in  8  env increment per tick in ATTACK
- decay_rate  in  8  env decrement per tick in DECAY
- sustain_level  in  10  sustain envelope level
- release_rate  in  8  env decrement per tick in RELEASE
- wave_out  out  10  enveloped sample, offset-binary
- env  out  10  current envelope level, 0..1023
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, env=0, wave_out=512, busy=0, tick counter=0.
- Tick: free-running counter 0..TICK_DIV-1; one-cycle tick when counter==TICK_DIV-1, then wraps to 0. Counter is not reset by gate.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Transitions are registered and take effect on the clock edge after the condition.
- IDLE: env=0. gate=1 -> ATTACK.
- ATTACK, on tick: env = min(env+attack_rate, 1023). On reaching 1023 -> DECAY. attack_rate=0 sets env=1023 on the next tick.
- DECAY, on tick: env = max(env-decay_rate, sustain_level). On reaching sustain_level -> SUSTAIN. decay_rate=0 jumps to sustain_level on the next tick.
- SUSTAIN: env follows sustain_level every clock, so live changes apply immediately.
- RELEASE, on tick: env = max(env-release_rate, 0). On reaching 0 -> IDLE. release_rate=0 gives env=0 on the next tick.
- Gate handling:
  - gate=0 in ATTACK, DECAY or SUSTAIN -> RELEASE on the next clock, independent of tick; env keeps its current value.
  - gate=1 in RELEASE -> ATTACK (retrigger from the current env, no jump to 0).
  - gate=0 and tick on the same cycle in ATTACK/DECAY: the state change to RELEASE wins and env is not stepped that cycle.
- Envelope arithmetic: 11-bit intermediates, saturating; env never wraps.
- Scaling, every clock, registered, 1-cycle latency from wave_in/env to wave_out:
  - s = wave_in - 512 (11-bit signed)
  - p = s*env (21-bit signed)
  - wave_out = 512 + (p >>> 10) (arithmetic shift, floor)
  - Result range is always 0..1022; no clamp is needed.
- busy is combinational from the state register.

Decomposition:
- Shared package adsr_pkg: state encoding (3-bit localparams for IDLE..RELEASE), ENV_MAX=1023, MID=512, ENV_W=10.
- One natural sub-module: tick_divider (parameter TICK_DIV, outputs a 1-cycle tick pulse). The FSM, envelope and scaler stay in adsr_envelope.

Test Plan:
- Reset with gate=0, wave_in=1023 -> wave_out=512, env=0, busy=0; wave_out stays 512 for 20 ticks.
- TICK_DIV=4, attack_rate=100, gate=1 held -> env reads 100, 200 … 1000 on successive ticks, then 1023 on tick 11 and state=DECAY. With wave_in=1023 at env=1023, wave_out=1022 one clock later.
- decay_rate=50, sustain_level=600 after full attack -> env 973, 923 … 623, then 600 (clamped) and state=SUSTAIN. Changing sustain_level to 300 gives env=300 on the next clock.
- gate falls during ATTACK at env=400, release_rate=128 -> RELEASE next clock; env 272, 144, 16, 0 on ticks; IDLE and busy=0 one clock after env reaches 0.
- gate re-asserted in RELEASE at env=144 -> ATTACK next clock with env=144; next tick env=244 (attack_rate=100).
- Scaling check with env=512: wave_in=0 -> 256, wave_in=1023 -> 767, wave_in=511 -> 511 (floor of -0.5); assert reset_n mid-ATTACK -> immediate env=0, wave_out=512, IDLE.
